// File: rtl/or_unit_arbiter.sv
// or_unit_arbiter: round-robin sharing of one external 74x32 OR package
// among NREQ requesters. The winner's operands are latched onto the shared
// unit and held for SETTLE cycles, then or_y is captured and returned along
// with the requester's ID.
// Optional build macro: OR_UNIT_ARB_STATS_EN adds the grant_count output,
// a saturating 16-bit count of completed operations.
module or_unit_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           ack,
  output logic                      busy,
  output logic [WIDTH-1:0]          or_a,
  output logic [WIDTH-1:0]          or_b,
  input  logic [WIDTH-1:0]          or_y,
  output logic                      rsp_valid,
  output logic [WIDTH-1:0]          rsp_data,
  output logic [$clog2(NREQ)-1:0]   rsp_id
`ifdef OR_UNIT_ARB_STATS_EN
  ,
  output logic [15:0]               grant_count
`endif
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    id_r, id_nxt;
  logic [WIDTH-1:0]   or_a_nxt, or_b_nxt;
  logic [WIDTH-1:0]   rsp_data_nxt;
  logic [ID_W-1:0]    rsp_id_nxt;
  logic [NREQ-1:0]    ack_nxt;
  logic               rsp_valid_nxt;
  logic               found;
  logic [ID_W-1:0]    win;
  int unsigned        idx;

  // State register and registered outputs, all loaded from next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      id_r      <= '0;
      or_a      <= '0;
      or_b      <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      ack       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      id_r      <= id_nxt;
      or_a      <= or_a_nxt;
      or_b      <= or_b_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_id    <= rsp_id_nxt;
      ack       <= ack_nxt;
      rsp_valid <= rsp_valid_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state logic: round-robin grant, settle countdown, result capture.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    cnt_nxt       = cnt;
    id_nxt        = id_r;
    or_a_nxt      = or_a;
    or_b_nxt      = or_b;
    rsp_data_nxt  = rsp_data;
    rsp_id_nxt    = rsp_id;
    ack_nxt       = '0;
    rsp_valid_nxt = 1'b0;
    found         = 1'b0;
    win           = '0;
    idx           = 0;

    // First requesting index at or after ptr, wrapping at NREQ.
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end

    unique case (state)
      IDLE: begin
        if (found) begin
          or_a_nxt  = req_a[win*WIDTH +: WIDTH];
          or_b_nxt  = req_b[win*WIDTH +: WIDTH];
          id_nxt    = win;
          cnt_nxt   = CNT_W'(SETTLE - 1);
          ptr_nxt   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          rsp_data_nxt  = or_y;
          rsp_id_nxt    = id_r;
          rsp_valid_nxt = 1'b1;
          ack_nxt[id_r] = 1'b1;
          state_nxt     = CAPTURE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CAPTURE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef OR_UNIT_ARB_STATS_EN
  // Saturating count of completed operations, one per CAPTURE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
    end else if (state == CAPTURE && grant_count != 16'hFFFF) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Directed self-checking bench for or_unit_arbiter (NREQ=4, WIDTH=2, SETTLE=2)
// with a behavioural 74x32 model closing the or_a/or_b -> or_y loop.
module tb_or_unit_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned WIDTH  = 2;
  localparam int unsigned SETTLE = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       ack;
  logic                  busy;
  logic [WIDTH-1:0]      or_a;
  logic [WIDTH-1:0]      or_b;
  logic [WIDTH-1:0]      or_y;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [1:0]            rsp_id;
`ifdef OR_UNIT_ARB_STATS_EN
  logic [15:0]           grant_count;
`endif

  int checks;
  int failures;

  or_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .busy       (busy),
    .or_a       (or_a),
    .or_b       (or_b),
    .or_y       (or_y),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id)
`ifdef OR_UNIT_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  // Shared 74x32 model.
  assign or_y = or_a | or_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [1:0] a, input logic [1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Per-requester operands and expected OR results for the all-request run.
  logic [1:0] rr_a [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] rr_b [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
  logic [1:0] rr_y [4] = '{2'b10, 2'b01, 2'b11, 2'b11};

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    req_a    = '0;
    req_b    = '0;

    // Reset values
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_or_a", 32'(or_a), 32'd0);
    check("rst_or_b", 32'(or_b), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single request from requester 2
    set_ops(2, 2'b01, 2'b10);
    req = 4'b0100;
    tick();                                   // edge E
    check("s_busy_e1", 32'(busy), 32'd1);
    check("s_or_a", 32'(or_a), 32'h1);
    check("s_or_b", 32'(or_b), 32'h2);
    check("s_valid_e1", 32'(rsp_valid), 32'd0);
    tick();                                   // E+1
    check("s_valid_e2", 32'(rsp_valid), 32'd0);
    tick();                                   // E+2 -> CAPTURE
    check("s_valid", 32'(rsp_valid), 32'd1);
    check("s_ack", 32'(ack), 32'h4);
    check("s_data", 32'(rsp_data), 32'h3);
    check("s_id", 32'(rsp_id), 32'd2);
    check("s_busy_cap", 32'(busy), 32'd1);
    req = '0;
    tick();                                   // E+3 -> IDLE
    check("s_valid_end", 32'(rsp_valid), 32'd0);
    check("s_ack_end", 32'(ack), 32'd0);
    check("s_busy_end", 32'(busy), 32'd0);
    check("s_or_a_kept", 32'(or_a), 32'h1);

    // All four requesting continuously from reset
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
    req = 4'b1111;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % 4;
      tick();                                 // grant edge, 4 edges apart
      check($sformatf("rr%0d_or_a", k), 32'(or_a), 32'(rr_a[w]));
      check($sformatf("rr%0d_or_b", k), 32'(or_b), 32'(rr_b[w]));
      tick();
      tick();
      check($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(w));
      check($sformatf("rr%0d_data", k), 32'(rsp_data), 32'(rr_y[w]));
      check($sformatf("rr%0d_ack", k), 32'(ack), 32'(1 << w));
      tick();
      check($sformatf("rr%0d_idle", k), 32'(busy), 32'd0);
    end
    req = '0;

    // Withdrawal after grant
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_ops(1, 2'b10, 2'b01);
    req = 4'b0010;
    tick();                                   // grant 1, ptr -> 2
    req = '0;
    set_ops(1, 2'b00, 2'b00);
    tick();
    tick();
    check("wd_ack", 32'(ack), 32'h2);
    check("wd_data", 32'(rsp_data), 32'h3);
    check("wd_id", 32'(rsp_id), 32'd1);
    tick();
    check("wd_idle", 32'(busy), 32'd0);

    // Reset mid-operation: ptr=2, requesters 2 and 3
    set_ops(2, 2'b01, 2'b00);
    set_ops(3, 2'b10, 2'b00);
    req = 4'b1100;
    tick();                                   // grant 2, ptr -> 3
    check("rm_or_a", 32'(or_a), 32'h1);
    rst = 1'b1;
    tick();                                   // reset during DRIVE
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_or_a0", 32'(or_a), 32'd0);
    check("rm_or_b0", 32'(or_b), 32'd0);
    check("rm_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    tick();                                   // grant from ptr=0 -> lowest (2)
    check("rm_valid2", 32'(rsp_valid), 32'd0);
    check("rm_regrant", 32'(or_a), 32'h1);
    tick();
    tick();
    check("rm_id", 32'(rsp_id), 32'd2);
    check("rm_ack", 32'(ack), 32'h4);
    req = '0;
    tick();

    // Requester 3 arrives during CAPTURE of requester 1 (ptr=3)
    set_ops(1, 2'b01, 2'b01);
    req = 4'b0010;
    tick();                                   // grant 1
    tick();
    tick();                                   // CAPTURE of 1
    check("nw_ack1", 32'(ack), 32'h2);
    check("nw_data1", 32'(rsp_data), 32'h1);
    set_ops(3, 2'b10, 2'b01);
    req = 4'b1000;
    tick();                                   // back to IDLE
    check("nw_idle", 32'(busy), 32'd0);
    tick();                                   // grant 3
    check("nw_busy", 32'(busy), 32'd1);
    check("nw_or_a", 32'(or_a), 32'h2);
    tick();
    tick();
    check("nw_id3", 32'(rsp_id), 32'd3);
    check("nw_data3", 32'(rsp_data), 32'h3);
    check("nw_ack3", 32'(ack), 32'h8);
    req = '0;
    tick();

`ifdef OR_UNIT_ARB_STATS_EN
    // Five operations, then reset clears the count
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("st_zero", 32'(grant_count), 32'd0);
    for (int k = 0; k < 5; k++) begin
      req = 4'b0001;
      tick();
      tick();
      tick();
      req = '0;
      tick();
    end
    check("st_five", 32'(grant_count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("st_clear", 32'(grant_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
